key_event_classifier: RTL and testbench
=======================================

# key_event_classifier

Classifies the debounced, synchronous key level into discrete user events: short press, double click, long press and (optionally) auto-repeat. Sits directly downstream of `debounce` (its `sync_out` drives `key_in`) and replaces raw rising-edge counting in the top level. Events leave through a one-entry valid/ready slot so LED, counter or UART consumers can stall without corrupting classification.

## Interface
- `CLOCK_HZ`, 12_000_000: clock frequency; `CLOCK_HZ/1000` ≥ 1 required.
- `LONG_PRESS_MS`, 500: hold time that produces LONG.
- `DOUBLE_CLICK_MS`, 250: maximum release gap for DOUBLE.
- `REPEAT_PERIOD_MS`, 100: REPEAT interval while held after LONG.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `key_in` in 1: debounced level, 1 = pressed, already synchronous to `clock`.
- `event_valid` out 1: event slot occupied.
- `event_ready` in 1: consumer accepts on `event_valid && event_ready`.
- `event_code` out 2: `event_t`; stable while `event_valid && !event_ready`.
- `overflow` out 1: sticky; an event was dropped; cleared only by `reset`.

## Operation
- Derived limits, in cycles: `X_CYC = X_MS * (CLOCK_HZ/1000)` (integer division). One shared counter, width `$clog2` of the largest limit. It clears on every state entry and increments each cycle in a timed state. The limit is hit when `cnt == X_CYC-1`.
- States:
  - WAIT_RELEASE (reset state): `key_in==0` → IDLE.
  - IDLE: `key_in==1` → HELD.
  - HELD: `key_in==0` → GAP. Otherwise, when the limit is hit → emit LONG, → LONG_HELD.
  - GAP: `key_in==1` → emit DOUBLE, → WAIT_RELEASE. Otherwise, when the limit is hit → emit SHORT, → IDLE.
  - LONG_HELD: `key_in==0` → IDLE. REPEAT behaviour is given under Configuration.
- Simultaneous events:
  - HELD, release on the limit cycle: release wins; SHORT path, no LONG.
  - GAP, press on the limit cycle: press wins; DOUBLE, no SHORT.
- `event_t` codes: EV_SHORT=0, EV_DOUBLE=1, EV_LONG=2, EV_REPEAT=3.
- Slot write rule:
  - An emitted event is loaded when the slot is empty, or when it is being accepted in the same cycle. In that case `event_valid` stays 1 and the code updates.
  - Otherwise the event is dropped and `overflow` ← 1. The FSM transitions regardless; it never stalls.
- Reset values: `event_valid`=0, `event_code`=0, `overflow`=0, state=WAIT_RELEASE, `cnt`=0.
- Reset mid-operation discards the pending event and any partial classification. A key held through reset produces no event until it is released and pressed again.

## Timing
- Decision-to-output latency is 1 cycle. The FSM decides at clock edge N; `event_valid`/`event_code` are visible after edge N.
- LONG becomes visible `LONG_CYC` edges after the edge that sampled the press, i.e. the edge that entered HELD.
- SHORT becomes visible `DOUBLE_CYC` edges after GAP entry.
- DOUBLE becomes visible 1 cycle after the second press is sampled.
- The slot clears at the accepting edge unless it is reloaded on that same edge.

## Configuration
- `KEY_EVENT_REPEAT_EN` defined:
  - In LONG_HELD, the counter runs.
  - Each time the `REPEAT_CYC` limit is hit, EV_REPEAT is emitted and the counter clears.
  - Release → IDLE with no further event.
- Undefined:
  - LONG_HELD only waits for release; the counter is held at 0.
  - EV_REPEAT is never produced. `REPEAT_PERIOD_MS` is ignored.

## Structure
- `key_event_pkg`: `event_t` enum (2-bit), `state_t` enum, `ms_to_cycles()` constant function.
- Sub-module `key_event_slot`: the one-entry valid/ready register with the drop/overflow logic.
- The FSM and counter stay in `key_event_classifier`.

## Test plan
All scenarios use `CLOCK_HZ`=1000 (1 cycle per ms), LONG=8, DOUBLE=4, REPEAT=3, and `event_ready`=1 unless stated.
- Press 3 cycles, release, stay idle → single SHORT (code 0) visible 4 cycles after release is sampled; nothing else.
- Press 2, release 2, press and hold 2, release → DOUBLE (code 1) 1 cycle after the second press; no SHORT, no LONG.
- Hold 20 cycles, with REPEAT_EN → LONG at press+8, then REPEAT at +11, +14, +17; without the macro → LONG only.
- Hold `event_ready`=0; SHORT, then a later LONG → slot keeps code 0, `overflow`=1. Raise ready → SHORT accepted; `overflow` stays 1.
- Release on exactly the 8th held cycle → SHORT path, no LONG. Second press on the 4th gap cycle → DOUBLE, no SHORT.
- `key_in`=1 across `reset` deassertion, held 20 cycles → no events. Release then a 2-cycle press → SHORT.

Source files
------------

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and helpers for the key event classifier.
// Event codes, FSM states and millisecond-to-cycle conversion.
package key_event_pkg;

  typedef enum logic [1:0] {
    EV_SHORT  = 2'd0,
    EV_DOUBLE = 2'd1,
    EV_LONG   = 2'd2,
    EV_REPEAT = 2'd3
  } event_t;

  typedef enum logic [2:0] {
    ST_WAIT_RELEASE = 3'd0,
    ST_IDLE         = 3'd1,
    ST_HELD         = 3'd2,
    ST_GAP          = 3'd3,
    ST_LONG_HELD    = 3'd4
  } state_t;

  function automatic int ms_to_cycles(input int ms, input int hz);
    return ms * (hz / 1000);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_slot.sv
// key_event_slot: one-entry valid/ready event register.
// New events load when empty or draining; otherwise they drop and set overflow.
module key_event_slot
  import key_event_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  event_t load_code,
  input  logic   ready,
  output logic   valid,
  output event_t code,
  output logic   overflow
);

  // Hold one event; replace it only when the consumer is taking it.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid    <= 1'b0;
      code     <= EV_SHORT;
      overflow <= 1'b0;
    end else if (load) begin
      if (!valid || ready) begin
        valid <= 1'b1;
        code  <= load_code;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_classifier.sv
// key_event_classifier: turns a debounced key level into SHORT/DOUBLE/LONG.
// Define KEY_EVENT_REPEAT_EN to also emit REPEAT while held after LONG.
module key_event_classifier
  import key_event_pkg::*;
#(
  parameter int CLOCK_HZ         = 12_000_000,
  parameter int LONG_PRESS_MS    = 500,
  parameter int DOUBLE_CLICK_MS  = 250,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   key_in,
  output logic   event_valid,
  input  logic   event_ready,
  output event_t event_code,
  output logic   overflow
);

  localparam int LONG_CYC = ms_to_cycles(LONG_PRESS_MS, CLOCK_HZ);
  localparam int DBL_CYC  = ms_to_cycles(DOUBLE_CLICK_MS, CLOCK_HZ);
  localparam int REP_CYC  = ms_to_cycles(REPEAT_PERIOD_MS, CLOCK_HZ);
  // One width for every build variant so the counter layout never changes.
  localparam int MAX_CYC  =
    max_int(max_int(LONG_CYC, DBL_CYC), REP_CYC);
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DBL_LIM  = CW'(DBL_CYC - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          long_hit;
  logic          gap_hit;
  logic          rep_hit;
  logic          lh_timed;
  logic          emit;
  event_t        emit_code;

  assign long_hit = (cnt == LONG_LIM);
  assign gap_hit  = (cnt == DBL_LIM);

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CW-1:0] REP_LIM = CW'(REP_CYC - 1);
  assign rep_hit  = (cnt == REP_LIM);
  assign lh_timed = 1'b1;
`else
  assign rep_hit  = 1'b0;
  assign lh_timed = 1'b0;
`endif

  // State register; a key held through reset is ignored until released.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_WAIT_RELEASE;
    else       state <= state_nx;
  end

  // Next state; key edges take priority over limits hit on the same cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_WAIT_RELEASE: if (!key_in) state_nx = ST_IDLE;
      ST_IDLE:         if (key_in)  state_nx = ST_HELD;
      ST_HELD: begin
        if (!key_in)       state_nx = ST_GAP;
        else if (long_hit) state_nx = ST_LONG_HELD;
      end
      ST_GAP: begin
        if (key_in)       state_nx = ST_WAIT_RELEASE;
        else if (gap_hit) state_nx = ST_IDLE;
      end
      ST_LONG_HELD:    if (!key_in) state_nx = ST_IDLE;
      default:         state_nx = ST_WAIT_RELEASE;
    endcase
  end

  // Event decode for the current cycle, loaded into the slot at the edge.
  always_comb begin
    emit      = 1'b0;
    emit_code = EV_SHORT;
    unique case (state)
      ST_HELD: begin
        if (key_in && long_hit) begin
          emit      = 1'b1;
          emit_code = EV_LONG;
        end
      end
      ST_GAP: begin
        if (key_in) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
        end else if (gap_hit) begin
          emit      = 1'b1;
          emit_code = EV_SHORT;
        end
      end
      ST_LONG_HELD: begin
        if (key_in && rep_hit) begin
          emit      = 1'b1;
          emit_code = EV_REPEAT;
        end
      end
      default: ;
    endcase
  end

  // Shared timer: clears on state entry and after each repeat.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (state == ST_LONG_HELD && emit) begin
      cnt <= '0;
    end else if (state == ST_HELD || state == ST_GAP ||
                 (state == ST_LONG_HELD && lh_timed)) begin
      cnt <= cnt + 1'b1;
    end
  end

  key_event_slot u_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (emit),
    .load_code (emit_code),
    .ready     (event_ready),
    .valid     (event_valid),
    .code      (event_code),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_key_event_classifier.sv
// tb_key_event_classifier: directed and randomized checks of key events.
// Random runs are compared with a run-length model of the key history.
module tb_key_event_classifier;

  localparam int LONG = 8;
  localparam int DBL  = 4;
  localparam int REP  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_in = 1'b0;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [1:0] event_code;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  bit         k[256];
  bit         r[256];
  logic       ov[256];
  logic [1:0] oc[256];
  logic       oo[256];
  int         ev[256];
  int         n;

  key_event_classifier #(
    .CLOCK_HZ         (1000),
    .LONG_PRESS_MS    (LONG),
    .DOUBLE_CLICK_MS  (DBL),
    .REPEAT_PERIOD_MS (REP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_in      (key_in),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_code  (event_code),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic clear_seq();
    n = 0;
  endtask

  task automatic push(input bit v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      k[n] = v;
      r[n] = 1'b1;
      n++;
    end
  endtask

  // Reset, then play k/r; sample index t is taken #1 after edge t.
  task automatic run_seq(input bit rst_key);
    @(negedge clock);
    reset = 1'b1;
    key_in = rst_key;
    event_ready = 1'b0;
    repeat (2) @(posedge clock);
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      reset = 1'b0;
      key_in = k[t];
      event_ready = r[t];
      @(posedge clock);
      #1;
      ov[t] = event_valid;
      oc[t] = event_code;
      oo[t] = overflow;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    key_in = 1'b0;
    event_ready = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (event_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", event_valid);
    end
    checks++;
    if (event_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_code: got %0d want 0", event_code);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_short();
    int c;
    clear_seq();
    push(0, 2); push(1, 3); push(0, 12);
    run_seq(1'b0);
    checks++;
    if (ov[9] !== 1'b1 || oc[9] !== 2'd0) begin
      errors++;
      $display("FAIL short_t9: valid=%b code=%0d want 1/0", ov[9], oc[9]);
    end
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (c !== 1) begin
      errors++;
      $display("FAIL short_count: got %0d want 1", c);
    end
  endtask

  task automatic test_double();
    int c;
    clear_seq();
    push(0, 2); push(1, 2); push(0, 2); push(1, 2); push(0, 10);
    run_seq(1'b0);
    checks++;
    if (ov[6] !== 1'b1 || oc[6] !== 2'd1) begin
      errors++;
      $display("FAIL double_t6: valid=%b code=%0d want 1/1", ov[6], oc[6]);
    end
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (c !== 1) begin
      errors++;
      $display("FAIL double_count: got %0d want 1", c);
    end
  endtask

  task automatic test_long_repeat();
    int c;
    int want;
    clear_seq();
    push(0, 2); push(1, 20); push(0, 10);
    run_seq(1'b0);
    checks++;
    if (ov[10] !== 1'b1 || oc[10] !== 2'd2) begin
      errors++;
      $display("FAIL long_t10: valid=%b code=%0d want 1/2", ov[10], oc[10]);
    end
`ifdef KEY_EVENT_REPEAT_EN
    want = 4;
    for (int j = 1; j <= 3; j++) begin
      checks++;
      if (ov[10+3*j] !== 1'b1 || oc[10+3*j] !== 2'd3) begin
        errors++;
        $display("FAIL repeat_t%0d: valid=%b code=%0d want 1/3",
                 10 + 3 * j, ov[10+3*j], oc[10+3*j]);
      end
    end
`else
    want = 1;
`endif
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (c !== want) begin
      errors++;
      $display("FAIL long_count: got %0d want %0d", c, want);
    end
  endtask

  task automatic test_overflow();
    clear_seq();
    push(0, 2); push(1, 3); push(0, 6); push(1, 10); push(0, 10);
    for (int t = 0; t < n; t++) r[t] = (t >= 26);
    run_seq(1'b0);
    checks++;
    if (ov[18] !== 1'b1 || oc[18] !== 2'd0 || oo[18] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_t18: v=%b c=%0d o=%b want 1/0/0",
               ov[18], oc[18], oo[18]);
    end
    checks++;
    if (ov[19] !== 1'b1 || oc[19] !== 2'd0 || oo[19] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_t19: v=%b c=%0d o=%b want 1/0/1",
               ov[19], oc[19], oo[19]);
    end
    checks++;
    if (ov[25] !== 1'b1 || oc[25] !== 2'd0) begin
      errors++;
      $display("FAIL ovf_hold: v=%b c=%0d want 1/0", ov[25], oc[25]);
    end
    checks++;
    if (ov[26] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_accept: valid=%b want 0", ov[26]);
    end
    checks++;
    if (oo[30] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b want 1", oo[30]);
    end
  endtask

  task automatic test_boundary();
    int c;
    clear_seq();
    push(0, 2); push(1, 8); push(0, 10);
    run_seq(1'b0);
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (ov[14] !== 1'b1 || oc[14] !== 2'd0 || c !== 1) begin
      errors++;
      $display("FAIL edge_release: v=%b c=%0d n=%0d want 1/0/1",
               ov[14], oc[14], c);
    end
    clear_seq();
    push(0, 2); push(1, 9); push(0, 10);
    run_seq(1'b0);
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (ov[10] !== 1'b1 || oc[10] !== 2'd2 || c !== 1) begin
      errors++;
      $display("FAIL edge_long: v=%b c=%0d n=%0d want 1/2/1",
               ov[10], oc[10], c);
    end
    clear_seq();
    push(0, 2); push(1, 2); push(0, 4); push(1, 2); push(0, 10);
    run_seq(1'b0);
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (ov[8] !== 1'b1 || oc[8] !== 2'd1 || c !== 1) begin
      errors++;
      $display("FAIL edge_press: v=%b c=%0d n=%0d want 1/1/1",
               ov[8], oc[8], c);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    clear_seq();
    push(0, 2); push(1, 2); push(0, 5); push(1, 2); push(0, 10);
    run_seq(1'b0);
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (ov[8] !== 1'b1 || oc[8] !== 2'd0 ||
        ov[15] !== 1'b1 || oc[15] !== 2'd0 || c !== 2) begin
      errors++;
      $display("FAIL b2b_shorts: t8=%b/%0d t15=%b/%0d n=%0d want two SHORT",
               ov[8], oc[8], ov[15], oc[15], c);
    end
  endtask

  task automatic test_hold_through_reset();
    int c;
    clear_seq();
    push(1, 20); push(0, 3); push(1, 2); push(0, 10);
    run_seq(1'b1);
    c = 0;
    for (int t = 0; t < n; t++) c += int'(ov[t]);
    checks++;
    if (ov[29] !== 1'b1 || oc[29] !== 2'd0 || c !== 1) begin
      errors++;
      $display("FAIL held_reset: v=%b c=%0d n=%0d want 1/0/1",
               ov[29], oc[29], c);
    end
  endtask

  task automatic test_reset_discard();
    clear_seq();
    push(0, 2); push(1, 3); push(0, 8);
    for (int t = 0; t < n; t++) r[t] = 1'b0;
    run_seq(1'b0);
    checks++;
    if (ov[n-1] !== 1'b1) begin
      errors++;
      $display("FAIL discard_pending: valid=%b want 1", ov[n-1]);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (event_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL discard_reset: v=%b o=%b want 0/0",
               event_valid, overflow);
    end
  endtask

  task automatic test_random();
    bit         rk;
    int         pos;
    int         p;
    int         l1;
    int         rr;
    int         l0;
    bit         v;
    bit         o;
    logic [1:0] c;
    for (int it = 0; it < 25; it++) begin
      clear_seq();
      rk = 1'($urandom_range(0, 1));
      if (rk) push(1, $urandom_range(1, 5));
      push(0, $urandom_range(0, 3));
      while (n < 150) begin
        push(1, $urandom_range(1, 12));
        push(0, $urandom_range(1, 7));
      end
      push(0, 10);
      for (int t = 0; t < n; t++) r[t] = ($urandom_range(0, 3) != 0);
      run_seq(rk);
      for (int t = 0; t < n; t++) ev[t] = -1;
      pos = 0;
      while (pos < n && k[pos]) pos++;
      while (pos < n) begin
        while (pos < n && !k[pos]) pos++;
        if (pos >= n) break;
        p = pos;
        l1 = 0;
        while (p + l1 < n && k[p+l1]) l1++;
        if (l1 > LONG) begin
          ev[p+LONG] = 2;
`ifdef KEY_EVENT_REPEAT_EN
          for (int e = p + LONG + REP; e < p + l1; e += REP) ev[e] = 3;
`endif
          pos = p + l1;
        end else begin
          rr = p + l1;
          if (rr >= n) break;
          l0 = 0;
          while (rr + l0 < n && !k[rr+l0]) l0++;
          if (l0 <= DBL && rr + l0 < n) begin
            ev[rr+l0] = 1;
            pos = rr + l0;
            while (pos < n && k[pos]) pos++;
          end else begin
            if (rr + DBL < n) ev[rr+DBL] = 0;
            pos = rr + l0;
          end
        end
      end
      v = 1'b0;
      o = 1'b0;
      c = 2'd0;
      for (int t = 0; t < n; t++) begin
        if (ev[t] >= 0) begin
          if (!v || r[t]) begin
            v = 1'b1;
            c = 2'(ev[t]);
          end else begin
            o = 1'b1;
          end
        end else if (v && r[t]) begin
          v = 1'b0;
        end
        checks++;
        if (ov[t] !== v || oo[t] !== o || (v && oc[t] !== c)) begin
          errors++;
          $display("FAIL random it%0d t%0d: v=%b c=%0d o=%b want %b/%0d/%b",
                   it, t, ov[t], oc[t], oo[t], v, c, o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_overflow();
    test_boundary();
    test_back_to_back();
    test_hold_through_reset();
    test_reset_discard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
